comb_arith_8b_sra: RTL and testbench

Combinational 8-bit arithmetic right shifter with a 3-bit shift amount. Sign-extends by replicating bit 7 into vacated MSBs. Used as a standalone datapath primitive in arithmetic/ALU blocks. The clock and reset ports exist for interface uniformity only; the result path is purely combinational.

---
 rtl/comb_arith_8b_sra_pkg.sv | 5 +
 rtl/comb_arith_8b_sra_sra_stage.sv | 20 ++
 rtl/comb_arith_8b_sra.sv | 43 ++++
 tb/tb_comb_arith_8b_sra.sv | 137 +++++++++++++
 4 files changed

// File: rtl/comb_arith_8b_sra_pkg.sv
// Shared width constants for the 8-bit arithmetic right shifter.
package comb_arith_8b_sra_pkg;
   localparam int DATA_W = 8;
   localparam int AMT_W  = 3;
endpackage

// File: rtl/comb_arith_8b_sra_sra_stage.sv
// One barrel-shifter stage: optionally shifts right by a fixed distance, filling with the sign.
module sra_stage
   import comb_arith_8b_sra_pkg::*;
#(
   parameter int SHIFT = 1
) (
   input  logic [DATA_W-1:0] din,
   input  logic              sel,
   input  logic              sign,
   output logic [DATA_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (sel) begin
         dout = {{SHIFT{sign}}, din[DATA_W-1:SHIFT]};
      end
   end

endmodule

// File: rtl/comb_arith_8b_sra.sv
// Combinational 8-bit arithmetic right shifter built as a three-stage log barrel shifter.
module comb_arith_8b_sra
   import comb_arith_8b_sra_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_,
   input  logic [AMT_W-1:0]  amt,
   output logic [DATA_W-1:0] out
);

   logic              sign;
   logic [DATA_W-1:0] s1;
   logic [DATA_W-1:0] s2;
   logic              unused_ctl;

   // clk/reset exist only for interface uniformity and never reach the datapath
   assign unused_ctl = clk ^ reset;

   assign sign = in_[DATA_W-1];

   sra_stage #(.SHIFT(1)) u_stage1 (
      .din  (in_),
      .sel  (amt[0]),
      .sign (sign),
      .dout (s1)
   );

   sra_stage #(.SHIFT(2)) u_stage2 (
      .din  (s1),
      .sel  (amt[1]),
      .sign (sign),
      .dout (s2)
   );

   sra_stage #(.SHIFT(4)) u_stage4 (
      .din  (s2),
      .sel  (amt[2]),
      .sign (sign),
      .dout (out)
   );

endmodule

// File: tb/tb_comb_arith_8b_sra.sv
// Self-checking bench for comb_arith_8b_sra: vector table, reset independence, random and exhaustive.
module tb_comb_arith_8b_sra;

   typedef struct {
      logic [7:0] in_v;
      logic [2:0] amt_v;
      logic [7:0] exp_v;
      string      name;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [7:0] in_;
   logic [2:0] amt;
   logic [7:0] out;

   int n_cmp;
   int n_err;

   logic [7:0] exp_q[$];
   vec_t       vecs[$];

   comb_arith_8b_sra dut (
      .clk   (clk),
      .reset (reset),
      .in_   (in_),
      .amt   (amt),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_sra(input logic [7:0] a, input logic [2:0] s);
      logic signed [7:0] r;
      r = $signed(a) >>> s;
      return r;
   endfunction

   task automatic add_vec(input logic [7:0] a, input logic [2:0] s, input logic [7:0] e,
                          input string nm);
      vec_t v;
      v.in_v  = a;
      v.amt_v = s;
      v.exp_v = e;
      v.name  = nm;
      vecs.push_back(v);
   endtask

   task automatic check_one(input string nm);
      logic [7:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, got %02h", nm, out);
      end else begin
         e = exp_q.pop_front();
         if (out !== e) begin
            n_err++;
            $display("FAIL %s: in_=%02h amt=%0d got %02h expected %02h", nm, in_, amt, out, e);
         end
      end
   endtask

   task automatic apply(input logic [7:0] a, input logic [2:0] s, input logic [7:0] e,
                        input string nm);
      in_ = a;
      amt = s;
      exp_q.push_back(e);
      #8;
      check_one(nm);
      #2;
   endtask

   localparam logic [7:0] POS_EXP [8] = '{8'h5D, 8'h2E, 8'h17, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
   localparam logic [7:0] NEG_EXP [8] = '{8'hD5, 8'hEA, 8'hF5, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};

   initial begin
      int unsigned seed;
      logic [7:0]  ra;
      logic [2:0]  rs;

      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      in_   = 8'h00;
      amt   = 3'd0;

      for (int i = 0; i < 8; i++) begin
         add_vec(8'h5D, 3'(i), POS_EXP[i], "pos_sweep");
         add_vec(8'hD5, 3'(i), NEG_EXP[i], "neg_sweep");
         add_vec(8'hFF, 3'(i), 8'hFF, "all_ones");
         add_vec(8'h00, 3'(i), 8'h00, "all_zeros");
      end
      add_vec(8'h80, 3'd7, 8'hFF, "min_neg_amt7");
      add_vec(8'h7F, 3'd7, 8'h00, "max_pos_amt7");
      add_vec(8'h80, 3'd1, 8'hC0, "min_neg_amt1");
      add_vec(8'h7F, 3'd1, 8'h3F, "max_pos_amt1");

      // output while reset held low must still follow the inputs
      apply(8'hD5, 3'd2, 8'hF5, "during_reset");
      #3 reset = 1'b1;

      foreach (vecs[k]) apply(vecs[k].in_v, vecs[k].amt_v, vecs[k].exp_v, vecs[k].name);

      // reset toggling with clk running must not disturb out
      in_ = 8'hD5;
      amt = 3'd3;
      for (int i = 0; i < 6; i++) begin
         reset = ~reset;
         exp_q.push_back(8'hFA);
         #4;
         check_one("reset_indep");
         @(posedge clk);
         #1;
      end
      reset = 1'b1;

      seed = 32'h1234_5678;
      ra = 8'($urandom(seed));
      for (int i = 0; i < 32; i++) begin
         ra = 8'($urandom);
         rs = 3'($urandom_range(7, 0));
         apply(ra, rs, ref_sra(ra, rs), "random");
      end

      for (int a = 0; a < 256; a++) begin
         for (int s = 0; s < 8; s++) begin
            apply(8'(a), 3'(s), ref_sra(8'(a), 3'(s)), "exhaustive");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
